// File: rtl/tick_sched_pkg.sv
// Shared defaults and state encodings for the tick scheduler.
package tick_sched_pkg;

    localparam int CLK_FREQ_DEFAULT = 12;  // clock cycles per microsecond
    localparam int NUM_CH_DEFAULT   = 4;   // timer channels (power of two)
    localparam int CNT_W_DEFAULT    = 16;  // period width in microseconds

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tick_sched_channel.sv
// One countdown channel: config registers, IDLE/RUN countdown on the
// shared microsecond tick, and the pending/overrun event flags.
module tick_sched_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             accept,
    output logic             busy,
    output logic             pending,
    output logic             overrun
);

    ch_state_t        state;
    logic [CNT_W-1:0] period_q;
    logic             oneshot_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] start_period;
    logic             start_go;
    logic             expire;

    // A start in the same cycle as a config write uses the value being written.
    assign start_period = cfg_we ? cfg_period : period_q;
    // Stop beats start; a zero period means the channel cannot be armed.
    assign start_go     = start && !stop && (start_period != '0);
    // Expiry is a tick landing on a zero count while nothing overrides it.
    assign expire       = (state == RUN) && tick && (cnt == '0) && !stop && !start_go;
    assign busy         = (state == RUN);

    // Configuration registers, loaded on a write to this channel.
    // NOTE: these are ordinary control registers, not a memory array, so they take the async reset like every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q  <= '0;
            oneshot_q <= 1'b0;
        end else if (cfg_we) begin
            period_q  <= cfg_period;
            oneshot_q <= cfg_oneshot;
        end
    end

    // Channel FSM and countdown: stop > start > tick.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (stop) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (start_go) begin
            state <= RUN;
            cnt   <= start_period - CNT_W'(1);
        end else if (state == RUN && tick) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else if (oneshot_q || period_q == '0) begin
                state <= IDLE;
            end else begin
                cnt <= period_q - CNT_W'(1);
            end
        end
    end

    // Event flags: an expiry coinciding with acceptance keeps pending set;
    // an expiry onto an unaccepted pending event is merged and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (expire) begin
                pending <= 1'b1;
            end else if (accept) begin
                pending <= 1'b0;
            end

            if (start && !stop) begin
                overrun <= 1'b0;
            end else if (expire && pending && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Shared 1 us timebase plus NUM_CH countdown channels whose expiry events
// are serialised round-robin onto one valid/ready event port.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter  int NUM_CH   = NUM_CH_DEFAULT,
    parameter  int CNT_W    = CNT_W_DEFAULT,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic              tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overrun,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready
);

    localparam int              PS_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ - 1);

    logic [PS_W-1:0]   prescaler;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] ch_cfg_we;
    arb_state_t        arb_state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;
    logic              found;

    // Free-running microsecond prescaler; tick marks its last count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    assign tick = (prescaler == PS_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_cfg_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        assign accept[i]    = (arb_state == ARB_OFFER) && evt_ready && (evt_ch == CH_W'(i));

        tick_sched_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_we      (ch_cfg_we[i]),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .start       (start[i]),
            .stop        (stop[i]),
            .tick        (tick),
            .accept      (accept[i]),
            .busy        (busy[i]),
            .pending     (pending[i]),
            .overrun     (overrun[i])
        );
    end

    // Round-robin search: first pending channel at or after ptr, wrapping.
    // NOTE: every output of this block gets a default before the loop, so no path leaves a value held and no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + CH_W'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Arbiter FSM: latch one event, hold it until accepted, then advance ptr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_state <= ARB_IDLE;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            ptr       <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: begin
                    if (found) begin
                        evt_ch    <= pick;
                        evt_valid <= 1'b1;
                        arb_state <= ARB_OFFER;
                    end
                end
                ARB_OFFER: begin
                    if (evt_ready) begin
                        ptr       <= evt_ch + CH_W'(1);
                        evt_valid <= 1'b0;
                        arb_state <= ARB_IDLE;
                    end
                end
                default: arb_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: stimulus pushes the expected
// (channel, cycle) of each delivered event; a monitor pops on handshake.
module tb_tick_scheduler;

    localparam int CLK_FREQ = 12;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int CH_W     = 2;

    logic              clk         = 1'b0;
    logic              reset       = 1'b0;
    logic              cfg_we      = 1'b0;
    logic [CH_W-1:0]   cfg_ch      = '0;
    logic [CNT_W-1:0]  cfg_period  = '0;
    logic              cfg_oneshot = 1'b0;
    logic [NUM_CH-1:0] start       = '0;
    logic [NUM_CH-1:0] stop        = '0;
    logic              evt_ready   = 1'b1;
    logic              tick;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] overrun;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;
    exp_t sb[$];

    tick_scheduler #(
        .CLK_FREQ (CLK_FREQ),
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .busy        (busy),
        .overrun     (overrun),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready)
    );

    always #5 clk = ~clk;

    // Cycle number since reset release; cycle 0 is the one containing release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, want);
        end
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cfg_we = 1'b0;
        start  = '0;
        stop   = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0;
        cfg_we = 1'b0;
        start  = '0;
        stop   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic expect_evt(input int ch, input int c);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic write_cfg(input int ch, input int period, input logic oneshot);
        cfg_we      = 1'b1;
        cfg_ch      = CH_W'(ch);
        cfg_period  = CNT_W'(period);
        cfg_oneshot = oneshot;
    endtask

    // Monitor: checks tick against the prescaler model every cycle and pops
    // the scoreboard on every accepted event.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check("tick", 32'(tick), 32'((cyc % CLK_FREQ) == CLK_FREQ - 1));
                if (evt_valid && evt_ready) begin
                    check("evt_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("evt_ch", 32'(evt_ch), 32'(e.ch));
                        check("evt_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release, idle run.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_ch", 32'(evt_ch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        goto(11);
        check("first_tick", 32'(tick), 32'd1);
        goto(40);
        check("idle_evt_valid", 32'(evt_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_overrun", 32'(overrun), 32'd0);

        // ch0 period 3 periodic, configured and started in the same cycle.
        reset_dut();
        goto(1);
        write_cfg(0, 3, 1'b0);
        start = 4'b0001;
        step();
        check("p3_busy_rise", 32'(busy), 32'b0001);
        expect_evt(0, 37);
        expect_evt(0, 73);
        expect_evt(0, 109);
        goto(36);
        check("p3_valid_before", 32'(evt_valid), 32'd0);
        goto(37);
        check("p3_valid_t2", 32'(evt_valid), 32'd1);
        goto(100);
        check("p3_busy_hold", 32'(busy), 32'b0001);
        goto(115);
        stop = 4'b0001;
        step();
        check("p3_busy_stop", 32'(busy), 32'd0);
        goto(150);

        // ch1 period 1 one-shot, then a start with period 0.
        reset_dut();
        goto(1);
        write_cfg(1, 1, 1'b1);
        step();
        start = 4'b0010;
        step();
        check("os_busy_rise", 32'(busy), 32'b0010);
        expect_evt(1, 13);
        goto(11);
        check("os_busy_at_tick", 32'(busy), 32'b0010);
        goto(12);
        check("os_busy_fall", 32'(busy), 32'd0);
        goto(41);
        write_cfg(1, 0, 1'b0);
        step();
        start = 4'b0010;
        step();
        check("p0_busy", 32'(busy), 32'd0);
        goto(60);

        // ch0 and ch2 period 2 started together: round-robin ordering.
        reset_dut();
        goto(1);
        write_cfg(0, 2, 1'b0);
        step();
        write_cfg(2, 2, 1'b0);
        step();
        start = 4'b0101;
        step();
        check("rr_busy", 32'(busy), 32'b0101);
        expect_evt(0, 25);
        expect_evt(2, 27);
        expect_evt(0, 49);
        expect_evt(2, 51);
        goto(26);
        check("rr_gap", 32'(evt_valid), 32'd0);
        goto(52);
        stop = 4'b0101;
        step();
        check("rr_busy_stop", 32'(busy), 32'd0);
        goto(80);

        // ch3 period 1 periodic with consumer stalled: hold, overrun, merge.
        reset_dut();
        evt_ready = 1'b0;
        goto(1);
        write_cfg(3, 1, 1'b0);
        step();
        start = 4'b1000;
        step();
        goto(13);
        check("ov_valid", 32'(evt_valid), 32'd1);
        check("ov_ch", 32'(evt_ch), 32'd3);
        check("ov_overrun_first", 32'(overrun), 32'd0);
        goto(23);
        check("ov_overrun_before", 32'(overrun), 32'd0);
        goto(24);
        check("ov_overrun_set", 32'(overrun), 32'b1000);
        check("ov_ch_stable", 32'(evt_ch), 32'd3);
        check("ov_valid_stable", 32'(evt_valid), 32'd1);
        goto(26);
        start = 4'b1000;
        step();
        check("ov_overrun_clr", 32'(overrun), 32'd0);
        goto(28);
        evt_ready = 1'b1;
        expect_evt(3, 28);
        expect_evt(3, 37);
        goto(38);
        stop = 4'b1000;
        step();
        goto(60);

        // Asynchronous reset while an event is offered.
        reset_dut();
        evt_ready = 1'b0;
        goto(1);
        write_cfg(1, 1, 1'b0);
        step();
        start = 4'b0010;
        step();
        goto(25);
        check("ar_valid_pre", 32'(evt_valid), 32'd1);
        check("ar_busy_pre", 32'(busy), 32'b0010);
        check("ar_overrun_pre", 32'(overrun), 32'b0010);
        #2 reset = 1'b0;
        #1;
        check("ar_valid_drop", 32'(evt_valid), 32'd0);
        check("ar_ch_drop", 32'(evt_ch), 32'd0);
        check("ar_busy_drop", 32'(busy), 32'd0);
        check("ar_overrun_drop", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        evt_ready = 1'b1;
        goto(10);
        check("ar_tick_10", 32'(tick), 32'd0);
        goto(11);
        check("ar_tick_11", 32'(tick), 32'd1);
        goto(40);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
